apb_rr_master: RTL and testbench

- Round-robin APB master that shares one APB slave (the 32-word APB RAM) between NUM_REQ local requesters.
- Each requester presents a simple valid/ready command and gets a one-cycle response pulse.
- The block arbitrates, sequences APB SETUP/ACCESS phases, handles wait states, and aborts hung transfers with a timeout.
- Sits between the system's requesters and the APB slave port.

---
 rtl/apb_rr_pkg.sv | 22 ++
 rtl/apb_rr_master_rr_arbiter.sv | 50 +++++
 rtl/apb_rr_master.sv | 151 +++++++++++++++
 tb/tb_apb_rr_master.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_rr_pkg.sv
// apb_rr_pkg: shared types and defaults for the round-robin APB master.
//   state_t   - transfer sequencer states (IDLE, SETUP, ACCESS)
//   DEF_*     - default widths, requester count and timeout
//   cnt_width - width of a counter that must hold values 0..t-1 (minimum 1)
package apb_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 16;

    function automatic int cnt_width(input int t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/apb_rr_master_rr_arbiter.sv
// rr_arbiter: round-robin pick among NUM_REQ requesters.
//   PCLK, PRESET - clock, synchronous active-high reset (pointer -> 0)
//   req          - request vector (already qualified by the caller)
//   advance      - grant taken this cycle; pointer moves past the winner
//   grant        - one-hot grant, zero when no request
//   grant_idx    - index of the granted requester
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Scan upward from the pointer with wrap; first hit wins.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        grant     = '0;
        grant_idx = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant     = '0;
                grant[idx] = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: shares one APB slave between NUM_REQ valid/ready requesters.
//   PCLK, PRESET          - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester command handshake (ready one-hot)
//   req_addr/write/wdata  - packed per-requester command fields
//   rsp_valid             - one-hot, one-cycle response pulse
//   rsp_rdata, rsp_err    - response payload, held until the next response
//   PSEL..PSLVERR         - APB master port
// A hung ACCESS phase is aborted with rsp_err after TIMEOUT cycles (0 = never).
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    state_t                 state_q, state_d;
    cmd_t                   cmd_q, cmd_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]     arb_req, arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic                   accept;
    logic                   timeout_hit;

    // Only offer requests to the arbiter when a new command can be taken.
    assign arb_req   = req_valid & {NUM_REQ{(state_q == ST_IDLE) && !PRESET}};
    assign accept    = |arb_grant;
    assign req_ready = arb_grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (arb_req),
        .advance   (accept),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        gidx_d      = gidx_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d   = '{addr: addr_v[arb_idx], write: req_write[arb_idx],
                                wdata: wdata_v[arb_idx]};
                    gidx_d  = arb_idx;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY takes priority so a completion on the last allowed
                // cycle is not reported as a timeout.
                if (PREADY) begin
                    rsp_valid_d = NUM_REQ'(1) << gidx_q;
                    rsp_rdata_d = cmd_q.write ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    state_d     = ST_IDLE;
                end else if (timeout_hit) begin
                    rsp_valid_d = NUM_REQ'(1) << gidx_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            gidx_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            gidx_q      <= gidx_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PSEL      = (state_q != ST_IDLE);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PADDR     = cmd_q.addr;
    assign PWRITE    = cmd_q.write;
    assign PWDATA    = cmd_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed + randomized bench for apb_rr_master with a
// 32-word APB RAM slave model (addresses >= 32 answer PSLVERR).
module tb_apb_rr_master;

    localparam int N  = 3;
    localparam int TO = 8;

    logic            PCLK = 1'b0;
    logic            PRESET = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_addr = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*32-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            PSEL, PENABLE, PWRITE;
    logic [31:0]     PADDR, PWDATA;
    logic [31:0]     PRDATA = '0;
    logic            PREADY = 1'b0;
    logic            PSLVERR = 1'b0;

    apb_rr_master #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // ---------------- slave model ----------------
    int          slv_waits = 0;
    bit          slv_hang  = 1'b0;
    int          acc_cnt   = 0;
    logic [31:0] slv_mem [32] = '{default: 32'h0};

    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (!slv_hang && acc_cnt >= slv_waits) begin
                PREADY  = 1'b1;
                PSLVERR = (PADDR >= 32);
                PRDATA  = PSLVERR ? 32'h0 : slv_mem[PADDR[4:0]];
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            PREADY  = 1'($urandom_range(0, 1));
            PSLVERR = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
        end
    end

    always @(posedge PCLK) begin
        if (!PRESET && PSEL && PENABLE && PREADY && PWRITE && PADDR < 32)
            slv_mem[PADDR[4:0]] <= PWDATA;
    end

    // ---------------- reference model & checking ----------------
    logic [31:0] ref_mem [32] = '{default: 32'h0};
    int          m_ptr = 0;
    int          pass_cnt = 0;
    int          total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    // First requester in mask at or above ptr, wrapping.
    function automatic int pick(input int ptr, input logic [N-1:0] m);
        for (int i = 0; i < N; i++)
            if (m[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [31:0] oh(input int r);
        return (r < 0) ? 32'h0 : (32'h1 << r);
    endfunction

    task automatic wait_ready();
        int c = 0;
        while (req_ready === '0 && c < 20) begin
            @(negedge PCLK); #1; c++;
        end
    endtask

    task automatic run_txn(input string tag, input int r, input logic [31:0] a,
                           input logic w, input logic [31:0] d,
                           input int waits, input bit hang);
        int          cyc;
        bit          stable;
        bit          timed_out;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_err;
        timed_out = hang || (waits >= TO);
        exp_lat   = timed_out ? 2 + TO : 3 + waits;
        if (timed_out || a >= 32) begin
            exp_rd = 0; exp_err = 1'b1;
        end else if (w) begin
            exp_rd = 0; exp_err = 1'b0; ref_mem[a[4:0]] = d;
        end else begin
            exp_rd = ref_mem[a[4:0]]; exp_err = 1'b0;
        end

        @(negedge PCLK);
        slv_waits = waits; slv_hang = hang;
        req_addr[r*32 +: 32] = a; req_write[r] = w; req_wdata[r*32 +: 32] = d;
        req_valid[r] = 1'b1;
        #1;
        wait_ready();
        chk({tag, ":ready"}, 32'(req_ready), oh(r));
        m_ptr = (r + 1) % N;

        // Scramble the command after acceptance: the latched copy must be used.
        @(negedge PCLK);
        req_valid[r] = 1'b0;
        req_addr[r*32 +: 32] = $urandom; req_wdata[r*32 +: 32] = $urandom;
        req_write[r] = ~w;
        #1;
        chk({tag, ":setup"}, 32'({PSEL, PENABLE}), 32'h2);

        @(negedge PCLK); #1;
        cyc = 2; stable = 1'b1;
        while (rsp_valid === '0 && cyc < 40) begin
            stable &= (PSEL === 1'b1 && PENABLE === 1'b1 && PADDR === a &&
                       PWRITE === w && PWDATA === d);
            @(negedge PCLK); #1; cyc++;
        end
        chk({tag, ":access_stable"}, 32'(stable), 32'h1);
        chk({tag, ":latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, ":rsp_valid"}, 32'(rsp_valid), oh(r));
        chk({tag, ":rsp_rdata"}, rsp_rdata, exp_rd);
        chk({tag, ":rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, ":psel_drop"}, 32'(PSEL), 32'h0);

        @(negedge PCLK); #1;
        chk({tag, ":rsp_pulse"}, 32'(rsp_valid), 32'h0);
        chk({tag, ":rdata_hold"}, rsp_rdata, exp_rd);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          grants;
        int          cyc;
        int          exp_g;
        logic [N-1:0] mask;

        // Reset: outputs cleared, req_ready forced low despite pending requests.
        PRESET = 1'b1;
        req_valid = 3'b011;
        repeat (2) @(negedge PCLK);
        #1;
        chk("rst:psel", 32'(PSEL), 0);
        chk("rst:penable", 32'(PENABLE), 0);
        chk("rst:rsp_valid", 32'(rsp_valid), 0);
        chk("rst:rsp_err", 32'(rsp_err), 0);
        chk("rst:rsp_rdata", rsp_rdata, 0);
        chk("rst:paddr", PADDR, 0);
        chk("rst:req_ready", 32'(req_ready), 0);

        // Fairness: req0/req1 held from reset, 8 grants alternate starting at 0.
        @(negedge PCLK);
        PRESET = 1'b0;
        slv_waits = 0; slv_hang = 1'b0;
        m_ptr = 0; grants = 0; cyc = 0;
        #1;
        while (grants < 8 && cyc < 200) begin
            if (req_ready !== '0) begin
                exp_g = pick(m_ptr, req_valid);
                chk("fair:grant", 32'(req_ready), oh(exp_g));
                m_ptr = (exp_g + 1) % N;
                grants++;
            end
            @(negedge PCLK); #1; cyc++;
        end
        chk("fair:count", 32'(grants), 8);
        req_valid = '0;
        repeat (5) @(negedge PCLK);

        // Directed transfers.
        run_txn("wr0",      0, 32'd5,  1'b1, 32'hDEADBEEF, 0, 1'b0);
        run_txn("rd0",      0, 32'd5,  1'b0, 32'h0,        0, 1'b0);
        run_txn("wait3",    1, 32'd7,  1'b1, 32'h1234_5678, 3, 1'b0);
        run_txn("rd_wait",  2, 32'd7,  1'b0, 32'h0,        2, 1'b0);
        run_txn("tmo",      0, 32'd9,  1'b1, 32'hCAFE_F00D, 0, 1'b1);
        run_txn("tmo_edge", 1, 32'd5,  1'b0, 32'h0,        TO - 1, 1'b0);
        run_txn("slverr",   0, 32'd40, 1'b0, 32'h0,        0, 1'b0);

        // Reset during the 2nd wait cycle of ACCESS.
        @(negedge PCLK);
        slv_hang = 1'b1;
        req_addr[32 +: 32] = 32'd3; req_write = '0; req_valid[1] = 1'b1;
        #1;
        wait_ready();
        chk("rstmid:ready", 32'(req_ready), oh(1));
        @(negedge PCLK); req_valid = '0;       // SETUP
        @(negedge PCLK);                       // ACCESS, wait 1
        @(negedge PCLK);                       // ACCESS, wait 2
        PRESET = 1'b1;
        req_valid = 3'b011;
        #1;
        chk("rstmid:ready_forced", 32'(req_ready), 0);
        @(negedge PCLK); #1;
        chk("rstmid:psel", 32'(PSEL), 0);
        chk("rstmid:penable", 32'(PENABLE), 0);
        chk("rstmid:no_rsp", 32'(rsp_valid), 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        slv_hang = 1'b0;
        m_ptr = 0;
        #1;
        chk("rstmid:first_grant", 32'(req_ready), oh(pick(m_ptr, req_valid)));
        m_ptr = (pick(m_ptr, req_valid) + 1) % N;
        @(negedge PCLK); req_valid = '0;
        repeat (4) @(negedge PCLK);

        // Randomized arbitration with contending requesters.
        for (int k = 0; k < 12; k++) begin
            @(negedge PCLK);
            mask = N'($urandom_range(1, (1 << N) - 1));
            req_valid = mask; req_write = '0; slv_waits = 0; slv_hang = 1'b0;
            #1;
            wait_ready();
            exp_g = pick(m_ptr, mask);
            chk("arb:grant", 32'(req_ready), oh(exp_g));
            m_ptr = (exp_g + 1) % N;
            @(negedge PCLK); req_valid = '0;
            repeat (3) @(negedge PCLK);
        end

        // Randomized single transfers against the memory model.
        for (int k = 0; k < 16; k++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, N - 1);
            a = ($urandom_range(0, 4) == 0) ? 32'(32 + $urandom_range(0, 7))
                                            : 32'($urandom_range(0, 7));
            run_txn("rnd", r, a, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
